spike_event_arbiter: RTL and testbench

Serialises parallel spike events from an 8-channel input layer onto one shared neuron-update datapath, one event per accepted transfer. Arrivals are latched into per-channel pending flags and granted round-robin through a valid/ready handshake. A timestep boundary pulse triggers a drain and a completion pulse. Sits between the input spike encoder and the shared LIF update unit inside `controller`.

---
 rtl/snn_pkg.sv | 12 +
 rtl/spike_event_arbiter_if.sv | 15 +
 rtl/spike_event_arbiter_rr_picker.sv | 44 ++++
 rtl/spike_event_arbiter.sv | 125 ++++++++++++
 tb/tb_spike_event_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network controller blocks.
package snn_pkg;

  localparam int N_CH_DEFAULT = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/spike_event_arbiter_if.sv
// Event handshake between the spike arbiter and the shared neuron-update datapath.
interface spike_event_arbiter_if
  import snn_pkg::*;
#(
  parameter int CH_W = $clog2(N_CH_DEFAULT)
);

  logic            ev_valid;
  logic [CH_W-1:0] ev_ch;
  logic            ev_ready;

  modport master (output ev_valid, output ev_ch, input ev_ready);
  modport slave  (input ev_valid, input ev_ch, output ev_ready);

endinterface

// File: rtl/spike_event_arbiter_rr_picker.sv
// Round-robin picker: rotate pending so rr_ptr sits at bit 0, take the lowest set bit,
// then rotate the index back.
module rr_picker
  import snn_pkg::*;
#(
  parameter int N_CH = N_CH_DEFAULT,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] pending_i,
  input  logic [CH_W-1:0] rr_ptr_i,
  output logic            found_o,
  output logic [CH_W-1:0] winner_o,
  output logic [N_CH-1:0] clear_o
);

  logic [N_CH-1:0] rotated;
  logic [CH_W-1:0] offset;
  logic [CH_W-1:0] srcIdx;

  // Index arithmetic wraps naturally because N_CH is a power of two.
  always_comb begin
    rotated = '0;
    srcIdx  = '0;
    for (int i = 0; i < N_CH; i++) begin
      srcIdx     = rr_ptr_i + CH_W'(i);
      rotated[i] = pending_i[srcIdx];
    end

    offset = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = CH_W'(i);
      end
    end

    found_o  = |pending_i;
    winner_o = rr_ptr_i + offset;
    clear_o  = '0;
    if (found_o) begin
      clear_o[winner_o] = 1'b1;
    end
  end

endmodule

// File: rtl/spike_event_arbiter.sv
// Latches per-channel spike events and serialises them round-robin onto one valid/ready
// port; a timestep pulse triggers a drain that ends with a one-cycle step_done.
module spike_event_arbiter
  import snn_pkg::*;
#(
  parameter int N_CH   = N_CH_DEFAULT,
  parameter int CH_W   = $clog2(N_CH),
  parameter int DROP_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_CH-1:0]       input_spike,
  input  logic                  step_in,
  spike_event_arbiter_if.master ev_if,
  output logic                  step_done,
  output logic                  busy,
  output logic [DROP_W-1:0]     drop_count
);

  localparam int CNT_W = $clog2(N_CH + 1);
  localparam int SUM_W = DROP_W + CNT_W;

  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [N_CH-1:0]   pending_q, pending_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [1:0]        state_q, state_d;
  logic              valid_q, valid_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              pickFound;
  logic [CH_W-1:0]   pickWinner;
  logic [N_CH-1:0]   pickClear;
  logic              loadSlot;
  logic [N_CH-1:0]   clearVec;
  logic [N_CH-1:0]   dropVec;
  logic [CNT_W-1:0]  dropInc;
  logic [SUM_W-1:0]  dropSum;

  rr_picker #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_picker (
    .pending_i (pending_q),
    .rr_ptr_i  (rr_ptr_q),
    .found_o   (pickFound),
    .winner_o  (pickWinner),
    .clear_o   (pickClear)
  );

  // The output register may reload only when empty or when its event is leaving this edge.
  always_comb begin
    loadSlot  = !valid_q || ev_if.ev_ready;
    clearVec  = (loadSlot && pickFound) ? pickClear : '0;
    pending_d = (pending_q & ~clearVec) | input_spike;

    valid_d  = valid_q;
    ch_d     = ch_q;
    rr_ptr_d = rr_ptr_q;
    if (loadSlot) begin
      valid_d = pickFound;
      if (pickFound) begin
        ch_d     = pickWinner;
        rr_ptr_d = pickWinner + CH_W'(1);
      end
    end
  end

  // A spike on a channel that is still pending (and not leaving now) is lost.
  always_comb begin
    dropVec = input_spike & pending_q & ~clearVec;
    dropInc = '0;
    for (int i = 0; i < N_CH; i++) begin
      dropInc = dropInc + CNT_W'(dropVec[i]);
    end
    dropSum = {{CNT_W{1'b0}}, drop_q} + {{DROP_W{1'b0}}, dropInc};
    drop_d  = (|dropSum[SUM_W-1:DROP_W]) ? {DROP_W{1'b1}} : dropSum[DROP_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (step_in) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((pending_q == '0) && (!valid_q || ev_if.ev_ready)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      rr_ptr_q  <= '0;
      state_q   <= ST_RUN;
      valid_q   <= 1'b0;
      ch_q      <= '0;
      drop_q    <= '0;
    end else begin
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      ch_q      <= ch_d;
      drop_q    <= drop_d;
    end
  end

  assign ev_if.ev_valid = valid_q;
  assign ev_if.ev_ch    = ch_q;
  assign step_done      = (state_q == ST_DONE);
  assign busy           = (|pending_q) || valid_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_spike_event_arbiter.sv
// Bench for spike_event_arbiter: a cycle-level reference model fills a scoreboard that a
// separate monitor drains on every handshake, plus directed checks on the key scenarios.
module tb_spike_event_arbiter;

  localparam int N   = 8;
  localparam int CHW = 3;
  localparam int DW  = 8;
  localparam int DROP_MAX = 255;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [N-1:0] inputSpike = '0;
  logic         stepIn = 1'b0;
  logic         stepDone;
  logic         busy;
  logic [DW-1:0] dropCount;

  spike_event_arbiter_if #(.CH_W(CHW)) evIf ();

  spike_event_arbiter #(
    .N_CH   (N),
    .CH_W   (CHW),
    .DROP_W (DW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .input_spike (inputSpike),
    .step_in     (stepIn),
    .ev_if       (evIf.master),
    .step_done   (stepDone),
    .busy        (busy),
    .drop_count  (dropCount)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  int cycleCnt    = 0;
  int stepCycle   = 0;

  int expQ[$];
  int gotLog[$];
  int hsCycle[$];
  int doneLog[$];

  // Reference model: pending set, pointer, presented event, drop tally, drain phase.
  bit mPend[N];
  int mPtr   = 0;
  bit mValid = 1'b0;
  int mCh    = 0;
  int mDrop  = 0;
  int mPhase = 0;
  int mWin;
  int mDrops;
  bit mAny;
  bit mSlot;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] spike, input logic step, input logic ready);
    @(posedge clk);
    #1;
    inputSpike    = spike;
    stepIn        = step;
    evIf.ev_ready = ready;
  endtask

  task automatic idleCycles(input int n, input logic ready);
    repeat (n) applyStimulus('0, 1'b0, ready);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset_n       = 1'b0;
    inputSpike    = '0;
    stepIn        = 1'b0;
    evIf.ev_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Model: compare current-cycle outputs, then advance by the rules of one clock edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < N; c++) mPend[c] = 1'b0;
      mPtr = 0; mValid = 1'b0; mCh = 0; mDrop = 0; mPhase = 0;
      expQ.delete();
    end else begin
      mAny = 1'b0;
      for (int c = 0; c < N; c++) mAny |= mPend[c];

      checkOutput("ev_valid", int'(evIf.ev_valid), int'(mValid));
      if (mValid) checkOutput("ev_ch_hold", int'(evIf.ev_ch), mCh);
      checkOutput("busy", int'(busy), int'(mAny || mValid));
      checkOutput("step_done", int'(stepDone), int'(mPhase == 2));
      checkOutput("drop_count", int'(dropCount), mDrop);

      mSlot = !mValid || evIf.ev_ready;
      mWin  = -1;
      if (mSlot) begin
        for (int i = 0; i < N; i++) begin
          if (mWin < 0 && mPend[(mPtr + i) % N]) mWin = (mPtr + i) % N;
        end
      end

      mDrops = 0;
      for (int c = 0; c < N; c++) begin
        if (inputSpike[c] && mPend[c] && c != mWin) mDrops++;
      end
      mDrop = (mDrop + mDrops > DROP_MAX) ? DROP_MAX : mDrop + mDrops;

      if (mPhase == 0) begin
        if (stepIn) mPhase = 1;
      end else if (mPhase == 1) begin
        if (!mAny && (!mValid || evIf.ev_ready)) mPhase = 2;
      end else begin
        mPhase = 0;
      end

      if (mWin >= 0) mPend[mWin] = 1'b0;
      for (int c = 0; c < N; c++) begin
        if (inputSpike[c]) mPend[c] = 1'b1;
      end

      if (mSlot) begin
        if (mWin >= 0) begin
          mValid = 1'b1;
          mCh    = mWin;
          mPtr   = (mWin + 1) % N;
          expQ.push_back(mWin);
        end else begin
          mValid = 1'b0;
        end
      end
    end
  end

  // Monitor: every completed transfer pops the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (evIf.ev_valid && evIf.ev_ready) begin
        gotLog.push_back(int'(evIf.ev_ch));
        hsCycle.push_back(cycleCnt);
        if (expQ.size() == 0) checkOutput("sb_nonempty", expQ.size(), 1);
        else checkOutput("sb_ev_ch", int'(evIf.ev_ch), expQ.pop_front());
      end
      if (stepDone) doneLog.push_back(cycleCnt);
    end
  end

  initial begin
    evIf.ev_ready = 1'b0;

    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_valid", int'(evIf.ev_valid), 0);
    checkOutput("rst_ch", int'(evIf.ev_ch), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_step_done", int'(stepDone), 0);
    checkOutput("rst_drop", int'(dropCount), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idleCycles(2, 1'b1);

    // Burst on all channels drains in index order.
    gotLog.delete();
    applyStimulus(8'hFF, 1'b0, 1'b1);
    idleCycles(12, 1'b1);
    checkOutput("burst_len", gotLog.size(), 8);
    for (int i = 0; i < 8 && i < gotLog.size(); i++) checkOutput("burst_ch", gotLog[i], i);
    checkOutput("burst_drop", int'(dropCount), 0);
    checkOutput("burst_busy", int'(busy), 0);

    // Backpressure holds channel 3 until ready returns.
    gotLog.delete();
    applyStimulus(8'h08, 1'b0, 1'b0);
    idleCycles(6, 1'b0);
    @(negedge clk);
    checkOutput("bp_valid", int'(evIf.ev_valid), 1);
    checkOutput("bp_ch", int'(evIf.ev_ch), 3);
    checkOutput("bp_none_yet", gotLog.size(), 0);
    idleCycles(4, 1'b1);
    checkOutput("bp_len", gotLog.size(), 1);
    if (gotLog.size() > 0) checkOutput("bp_xfer_ch", gotLog[0], 3);

    // Output stalled on ch0, then two full-width bursts: second one loses all 8.
    doReset();
    applyStimulus(8'h01, 1'b0, 1'b0);
    idleCycles(2, 1'b0);
    applyStimulus(8'hFF, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b0, 1'b0);
    idleCycles(1, 1'b0);
    @(negedge clk);
    checkOutput("drop_eight", int'(dropCount), 8);

    // Second burst coincides with the ch0 load: ch0 re-pends and only 7 are lost.
    doReset();
    gotLog.delete();
    applyStimulus(8'hFF, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b0, 1'b0);
    idleCycles(1, 1'b0);
    @(negedge clk);
    checkOutput("drop_seven", int'(dropCount), 7);
    idleCycles(12, 1'b1);
    checkOutput("repend_len", gotLog.size(), 9);
    for (int i = 0; i < 9 && i < gotLog.size(); i++) checkOutput("repend_ch", gotLog[i], i % 8);

    // Saturation of the drop counter under a stalled output.
    repeat (40) applyStimulus(8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("drop_sat", int'(dropCount), DROP_MAX);
    checkOutput("sat_valid", int'(evIf.ev_valid), 1);

    // Asynchronous reset mid-cycle with an event in flight.
    @(posedge clk);
    #2;
    reset_n    = 1'b0;
    inputSpike = '0;
    #1;
    checkOutput("mid_rst_valid", int'(evIf.ev_valid), 0);
    checkOutput("mid_rst_ch", int'(evIf.ev_ch), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_drop", int'(dropCount), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idleCycles(2, 1'b1);
    @(negedge clk);
    checkOutput("post_rst_busy", int'(busy), 0);

    // Two channels hammered every cycle must alternate.
    gotLog.delete();
    repeat (12) applyStimulus(8'h42, 1'b0, 1'b1);
    idleCycles(6, 1'b1);
    checkOutput("rr_enough", int'(gotLog.size() >= 8), 1);
    for (int i = 0; i < gotLog.size(); i++) checkOutput("rr_alt", gotLog[i], (i % 2 == 0) ? 1 : 6);

    // Step drain: ch0 then ch7, done pulse one cycle after the last transfer.
    doReset();
    gotLog.delete();
    hsCycle.delete();
    doneLog.delete();
    applyStimulus(8'h81, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b1, 1'b1);
    idleCycles(6, 1'b1);
    checkOutput("drain_len", gotLog.size(), 2);
    if (gotLog.size() == 2) begin
      checkOutput("drain_first", gotLog[0], 0);
      checkOutput("drain_second", gotLog[1], 7);
    end
    checkOutput("drain_pulses", doneLog.size(), 1);
    if (doneLog.size() == 1 && hsCycle.size() == 2) checkOutput("drain_done_cyc", doneLog[0], hsCycle[1] + 1);

    // Step while idle: done two cycles later.
    doneLog.delete();
    applyStimulus(8'h00, 1'b1, 1'b1);
    stepCycle = cycleCnt;
    idleCycles(5, 1'b1);
    checkOutput("idle_pulses", doneLog.size(), 1);
    if (doneLog.size() == 1) checkOutput("idle_done_cyc", doneLog[0], stepCycle + 2);

    // Randomised traffic with backpressure and sporadic timestep pulses.
    repeat (400) begin
      applyStimulus(N'($urandom & $urandom & $urandom), 1'($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 3) != 0));
    end
    idleCycles(20, 1'b1);
    @(negedge clk);
    checkOutput("sb_drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
